ex_multiplier: RTL
==================

# ex_multiplier

Sequential multiply unit in the EX stage, directly upstream of the EX/MEM pipeline register. It computes a 64-bit product of two 32-bit operands with one shift-add step per cycle, signed or unsigned. While it works it holds the pipeline through a stall output that gates the EX/MEM register enable. The finished product drives the EX/MEM register's 64-bit multiply-data input.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  multiply instruction present in EX (from the ID/EX control field); sampled only in IDLE.
- sign  in  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
- flush  in  1  kill the in-flight operation (branch/jump flush).
- opa  in  WIDTH  multiplicand (rs value after forwarding).
- opb  in  WIDTH  multiplier (rt value after forwarding).
- stall  out  1  combinational; 1 = hold PC, IF/ID, ID/EX and deassert EX/MEM en_reg.
- done  out  1  registered; 1 for exactly one cycle when product becomes valid.
- product  out  2*WIDTH  registered result, held until the next completion.

## Operation
- Clock is clk. Reset is synchronous and active-high on rst.
- States: IDLE, RUN, DONE. The encoding is defined in the shared package.
- IDLE, start=1 and flush=0:
  - latch |opa| into mcand and |opb| into the low half of acc; clear the high half of acc.
  - neg <= sign & (opa[WIDTH-1] ^ opb[WIDTH-1]).
  - cnt <= 0; go to RUN.
- RUN step:
  - if acc[0], add mcand to acc[2W-1:W] as a (WIDTH+1)-bit sum including carry.
  - shift the {carry, acc} result right by 1; cnt++.
  - on the step where cnt == WIDTH-1: product <= neg ? -(result) : result, mod 2^(2W); go to DONE.
- DONE: done=1; go to IDLE unconditionally. start is ignored, because the same instruction is still in EX.
- stall = (IDLE & start & ~flush) | RUN. stall is 0 in DONE, so EX/MEM captures product that cycle.
- Magnitude rule: |x| = sign & x[W-1] ? -x : x, taken as unsigned WIDTH bits. |0x80000000| = 0x80000000 is correct.
- Latency is fixed and does not depend on the data. Zero operands still take the full WIDTH steps.
- flush in RUN: return to IDLE next cycle. product and done are unchanged and stall drops the following cycle.
- flush in DONE: no effect, the unit goes to IDLE either way.
- flush in IDLE: start is suppressed that cycle.
- start in RUN: ignored.

## Timing
- Reset values: state=IDLE, product=0, done=0, acc=0, mcand=0, cnt=0, neg=0. stall=0 out of reset because it is combinational on IDLE with start low.
- Start accepted at edge 0. RUN occupies edges 1..WIDTH. done=1 and product valid in cycle WIDTH+1.
- stall is high for WIDTH+1 consecutive cycles (33 for WIDTH=32): the start cycle plus WIDTH RUN cycles.
- EX/MEM loads product on the edge that ends the DONE cycle.
- Back-to-back multiplies: the next start is accepted in the IDLE cycle immediately after DONE. There are no bubble cycles beyond the DONE cycle.
- rst mid-operation takes priority over everything. The unit is in IDLE with product=0 after that edge.

## Structure
- Shared package ex_mult_pkg holds:
  - WIDTH default;
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - counter width localparam $clog2(WIDTH).
- One sub-module, mult_step: combinational add-and-shift of one iteration. It takes acc, mcand and acc[0] and produces the next acc.
- The FSM, sign handling and stall logic stay in ex_multiplier.

## Test plan
- Unsigned basic: sign=0, opa=7, opb=6 -> stall high 33 cycles, done pulse, product=64'd42.
- Signed mixed: sign=1, opa=0xFFFFFFFD (-3), opb=5 -> product=0xFFFFFFFF_FFFFFFF1 (-15).
- Extremes:
  - sign=1, opa=opb=0x80000000 -> product=0x40000000_00000000.
  - sign=0, opa=opb=0xFFFFFFFF -> product=0xFFFFFFFE_00000001.
- Flush mid-run: start (3×4), then flush at RUN step 10 -> no done pulse, product keeps its previous value, stall low two cycles after flush. A new start then completes normally.
- Back-to-back: done for 2×3 is followed by start held high for 4×5 in the next cycle -> products 6 then 20, done pulses exactly 34 cycles apart.
- Reset in RUN: assert rst at RUN step 5 -> next cycle stall=0, done=0, product=0, state=IDLE.

Source files
------------

// File: rtl/ex_mult_pkg.sv
// Shared definitions for the EX-stage sequential multiplier: default width,
// FSM state encoding and iteration counter width.
package ex_mult_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/ex_mult_if.sv
// Operand/result bundle between the EX stage control and the multiplier.
// The master drives the request fields; the slave returns stall, done and product.
interface ex_mult_if
    import ex_mult_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic                 start;
    logic                 sign;
    logic                 flush;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 stall;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, sign, flush, opa, opb,
        input  stall, done, product
    );

    modport slave (
        input  start, sign, flush, opa, opb,
        output stall, done, product
    );
endinterface

// File: rtl/mult_step.sv
// One shift-add iteration: conditionally add mcand into the high half, then shift
// {carry, acc} right by one. Purely combinational, no backpressure.
module mult_step
    import ex_mult_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               add_en,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (add_en ? mcand : {WIDTH{1'b0}})};
        acc_next = {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/ex_multiplier.sv
// Sequential signed/unsigned multiplier: WIDTH shift-add steps, done in cycle WIDTH+1.
// Holds the pipeline via combinational stall from accepted start through the last RUN step.
module ex_multiplier
    import ex_mult_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    ex_mult_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    mult_state_t          state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mcand;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 accept;

    // Magnitudes are unsigned WIDTH bits, so the most negative value maps to itself.
    always_comb begin
        abs_a  = (bus.sign && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
        abs_b  = (bus.sign && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
        accept = (state == IDLE) && bus.start && !bus.flush;
    end

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .add_en   (acc[0]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= abs_a;
                        acc   <= {{WIDTH{1'b0}}, abs_b};
                        neg   <= bus.sign & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            product <= neg ? -acc_next : acc_next;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                // Same instruction is still in EX here, so start must not re-arm.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall   = accept || (state == RUN);
    assign bus.done    = done;
    assign bus.product = product;
endmodule
